// File: rtl/count_seg_display_if.sv
// Display-stage bus: counter value/direction in, segment pattern, flash flag and reversal count out.
interface count_seg_display_if #(
   parameter int NBITS_CNT = 6,
   parameter int NBITS_BNC = 8
);
   logic [NBITS_CNT-1:0] count_in;
   logic                 dir_in;
   logic [7:0]           SEG;
   logic                 flash;
   logic [NBITS_BNC-1:0] bounce_count;

   modport master (output count_in, dir_in, input SEG, flash, bounce_count);
   modport slave  (input count_in, dir_in, output SEG, flash, bounce_count);
endinterface

// File: rtl/count_seg_display.sv
// 7-segment display stage for the up/down counter, flashing on every direction reversal.
// Latency: input at edge k shows on SEG at edge k+1; free-running, no backpressure.
module count_seg_display #(
   parameter int NBITS_CNT   = 6,
   parameter int FLASH_PAIRS = 3,
   parameter int NBITS_BNC   = 8
) (
   input logic                 clk_2,
   input logic                 reset,
   count_seg_display_if.slave  bus
);
   localparam int NBITS_PAIRS = (FLASH_PAIRS > 1) ? $clog2(FLASH_PAIRS) : 1;
   localparam logic [NBITS_PAIRS-1:0] PAIRS_INIT = NBITS_PAIRS'(FLASH_PAIRS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   state_t                 state, state_nxt;
   logic [NBITS_PAIRS-1:0] pairs_left, pairs_nxt;
   logic [NBITS_CNT-1:0]   cnt_r;
   logic                   dir_r, dir_q, turn;
   logic [6:0]             glyph;
   logic [7:0]             digit, seg_r, seg_nxt;
   logic                   flash_r, flash_nxt;
   logic [NBITS_BNC-1:0]   bnc_r;

   always_ff @(posedge clk_2 or negedge reset) begin
      if (!reset) begin
         cnt_r <= '0;
         dir_r <= 1'b0;
         dir_q <= 1'b0;
      end else begin
         cnt_r <= bus.count_in;
         dir_r <= bus.dir_in;
         dir_q <= dir_r;
      end
   end

   assign turn = dir_r ^ dir_q;

   always_comb begin
      glyph = 7'h00;
      unique case (cnt_r[3:0])
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         4'hF: glyph = 7'h71;
      endcase
      // Anything above 15 cannot be shown as one hex digit: show a dash.
      if ((cnt_r >> 4) != '0)
         glyph = 7'h40;
      digit = {dir_r, glyph};
   end

   // Outputs are decoded from the state being entered, so they register with it.
   always_comb begin
      state_nxt = state;
      pairs_nxt = pairs_left;
      if (turn) begin
         state_nxt = BLANK;
         pairs_nxt = PAIRS_INIT;
      end else begin
         unique case (state)
            IDLE:  state_nxt = IDLE;
            BLANK: state_nxt = SHOW;
            SHOW: begin
               if (pairs_left == '0) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = BLANK;
                  pairs_nxt = pairs_left - 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      seg_nxt   = (state_nxt == BLANK) ? 8'h00 : digit;
      flash_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk_2 or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         pairs_left <= '0;
         seg_r      <= 8'h00;
         flash_r    <= 1'b0;
         bnc_r      <= '0;
      end else begin
         state      <= state_nxt;
         pairs_left <= pairs_nxt;
         seg_r      <= seg_nxt;
         flash_r    <= flash_nxt;
         if (turn && (bnc_r != '1))
            bnc_r <= bnc_r + NBITS_BNC'(1);
      end
   end

   assign bus.SEG          = seg_r;
   assign bus.flash        = flash_r;
   assign bus.bounce_count = bnc_r;
endmodule

// File: tb/tb_count_seg_display.sv
// Randomized scoreboard bench for count_seg_display against a reversal-distance reference model.
module tb_count_seg_display;
   localparam int FP = 3;

   typedef struct packed {
      logic [7:0] seg;
      logic       flash;
      logic [7:0] bnc;
   } exp_t;

   logic clk_2;
   logic reset;
   count_seg_display_if #(.NBITS_CNT(6), .NBITS_BNC(8)) bif ();

   count_seg_display #(.NBITS_CNT(6), .FLASH_PAIRS(FP), .NBITS_BNC(8)) dut (
      .clk_2 (clk_2),
      .reset (reset),
      .bus   (bif)
   );

   initial begin
      clk_2 = 1'b0;
      forever #5 clk_2 = ~clk_2;
   end

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   // Reference history: last two sampled directions, last sampled count,
   // edges elapsed since the last detected reversal, total reversals.
   logic       m_dir1, m_dir2;
   logic [5:0] m_cnt;
   int         m_since, m_bnc;
   logic [6:0] glyph_tab [16];

   initial begin
      glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   end

   function automatic logic [6:0] glyph_of(input logic [5:0] c);
      if (c > 6'd15) return 7'h40;
      return glyph_tab[c[3:0]];
   endfunction

   task automatic model_reset();
      m_dir1  = 1'b0;
      m_dir2  = 1'b0;
      m_cnt   = '0;
      m_since = 1000;
      m_bnc   = 0;
   endtask

   // Called at a negedge: predict the next edge's outputs, then drive new inputs.
   task automatic step(input logic [5:0] c, input logic d);
      exp_t e;
      if (m_dir1 != m_dir2) begin
         m_since = 0;
         if (m_bnc < 255) m_bnc++;
      end else if (m_since < 1000) begin
         m_since++;
      end
      e.flash = (m_since < 2 * FP);
      e.seg   = (e.flash && (m_since % 2 == 0)) ? 8'h00 : {m_dir1, glyph_of(m_cnt)};
      e.bnc   = 8'(m_bnc);
      exp_q.push_back(e);
      bif.count_in = c;
      bif.dir_in   = d;
      m_dir2 = m_dir1;
      m_dir1 = d;
      m_cnt  = c;
      @(negedge clk_2);
   endtask

   task automatic check_zero(input string name);
      n_checks++;
      if (bif.SEG !== 8'h00 || bif.flash !== 1'b0 || bif.bounce_count !== 8'h00) begin
         n_fail++;
         $display("FAIL %s: SEG=%h flash=%b bounce=%0d, required SEG=00 flash=0 bounce=0",
                  name, bif.SEG, bif.flash, bif.bounce_count);
      end
   endtask

   // Monitor: every active edge presents a new output set.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_2);
         #1;
         if (reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bif.SEG !== e.seg || bif.flash !== e.flash || bif.bounce_count !== e.bnc) begin
               n_fail++;
               $display("FAIL out @%0t: SEG=%h flash=%b bounce=%0d, required SEG=%h flash=%b bounce=%0d",
                        $time, bif.SEG, bif.flash, bif.bounce_count, e.seg, e.flash, e.bnc);
            end
         end
      end
   end

   initial begin
      logic d;
      reset        = 1'b0;
      bif.count_in = '0;
      bif.dir_in   = 1'b0;
      model_reset();
      #1 check_zero("reset_initial");

      repeat (6) begin
         bif.count_in = 6'($urandom_range(0, 63));
         bif.dir_in   = 1'($urandom_range(0, 1));
         @(negedge clk_2);
         check_zero("reset_hold");
      end
      reset = 1'b1;

      for (int i = 0; i < 16; i++) step(6'(i), 1'b0);
      step(6'd20, 1'b0);
      step(6'd20, 1'b0);
      repeat (9) step(6'd20, 1'b1);

      repeat (3) step(6'd15, 1'b0);
      repeat (10) step(6'd15, 1'b1);

      repeat (3) step(6'd9, 1'b1);
      repeat (3) step(6'd9, 1'b0);
      repeat (12) step(6'd9, 1'b1);

      d = 1'b0;
      repeat (300) begin
         if ($urandom_range(0, 7) == 0) d = ~d;
         step(6'($urandom_range(0, 63)), d);
      end

      repeat (320) begin
         d = ~d;
         step(6'($urandom_range(0, 15)), d);
      end
      repeat (3) step(6'd4, d);
      n_checks++;
      if (bif.bounce_count !== 8'd255) begin
         n_fail++;
         $display("FAIL bounce_saturate: bounce=%0d, required 255", bif.bounce_count);
      end

      repeat (3) step(6'd3, 1'b0);
      repeat (3) step(6'd3, 1'b1);
      #2 reset = 1'b0;
      #1 check_zero("reset_midflash");
      exp_q.delete();
      model_reset();
      repeat (3) begin
         bif.count_in = 6'($urandom_range(0, 63));
         bif.dir_in   = 1'($urandom_range(0, 1));
         @(negedge clk_2);
         check_zero("reset_midflash_hold");
      end
      bif.dir_in = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 12; i++) step(6'($urandom_range(0, 63)), 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
